riscv_operand_fetch: RTL and testbench
======================================

# riscv_operand_fetch

Register-file and operand-latch stage for the RISC-V datapath. Holds the 32 x 32-bit integer registers, reads two source registers per request, and presents them as registered operands A and B to the ALU stage directly downstream. A single write port accepts results from writeback. A valid/ready handshake on both sides lets the ALU stage stall the pipeline.

## Interface
Parameters:
- `XLEN`, default 32: register and operand width.
- `REG_NUM`, default 32: number of architectural registers; address width is fixed at 5.

Ports:
- `clk_i`, in, 1: clock; all state updates on the rising edge.
- `rstn_i`, in, 1: reset, asynchronous, active-low.
- `rs_valid_i`, in, 1: read request valid.
- `rs_ready_o`, out, 1: stage can accept a request this cycle.
- `rs1_addr_i`, in, 5: source register 1 index.
- `rs2_addr_i`, in, 5: source register 2 index.
- `op_a_o`, out, XLEN: registered operand A, fed to ALU `A`.
- `op_b_o`, out, XLEN: registered operand B, fed to ALU `B`.
- `op_valid_o`, out, 1: operands valid.
- `op_ready_i`, in, 1: ALU stage consumes operands this cycle.
- `we_i`, in, 1: writeback enable.
- `wa_i`, in, 5: writeback register index.
- `wd_i`, in, XLEN: writeback data.

## Operation
- **Register x0:**
  - Reads always return 0.
  - Writes with `wa_i`=0 are discarded.
- **Write:**
  - When `we_i`=1 and `wa_i`!=0, `regs[wa_i]` takes `wd_i` at the rising edge.
  - Writes are independent of the handshake state.
- **Read:** combinational from the array contents before the current edge; the read is not bypassed unless `RF_BYPASS_EN` is defined.
- **Operand latch:** a single-entry register, with states EMPTY (`op_valid_o`=0) and FULL (`op_valid_o`=1).
  - `rs_ready_o` = !`op_valid_o` || `op_ready_i`.
  - Accept when `rs_valid_i` && `rs_ready_o`: `op_a_o`/`op_b_o` take the read data and `op_valid_o` is set to 1.
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept with `op_ready_i`=1 (back-to-back).
  - FULL -> EMPTY when `op_ready_i`=1 and there is no accept.
  - FULL with `op_ready_i`=0: `op_a_o`/`op_b_o` hold bit-stable and `rs_ready_o`=0.
- **Hazard on held operands:** a write to a register already captured in FULL does not update the held operand. The captured value is final. Ordering is the issuer's responsibility.
- **Reset (`rstn_i`=0, any time, including mid-transfer):**
  - All 32 registers clear to 0.
  - `op_valid_o`=0, `op_a_o`=0, `op_b_o`=0.
  - Any in-flight operand is dropped.
  - `rs_ready_o`=1 once `op_valid_o`=0.
  - Writes presented during reset are ignored.

## Timing
- Latency: request accepted at edge N -> operands valid from N for 1+ cycles, i.e. visible the cycle after acceptance.
- Throughput: one request per cycle while `op_ready_i`=1.
- `rs_ready_o` is combinational from `op_valid_o` and `op_ready_i`. No other combinational paths exist from inputs to outputs.
- Write-to-read visibility:
  - A write at edge N is seen by any request accepted at edge N+1 or later.
  - For a request accepted at the same edge N, visibility depends on `RF_BYPASS_EN`.
- Reset assertion takes effect immediately, independent of `clk_i`. Deassertion is synchronised externally.

## Configuration
- Macro: `RF_BYPASS_EN`.
- **Defined:** write-through bypass.
  - On an accept with `we_i`=1, `wa_i`!=0 and `wa_i`==`rs1_addr_i`, `op_a_o` captures `wd_i`.
  - The same applies independently to `rs2_addr_i`/`op_b_o`.
  - Both operands bypass if both addresses match.
- **Undefined:** no bypass; a same-edge write is invisible to the captured operand, which takes the old value.

## Test plan
- **Reset:** assert `rstn_i`=0 mid-run with `op_valid_o`=1 -> immediately `op_valid_o`=0, `op_a_o`=`op_b_o`=0, `rs_ready_o`=1. After release, reading x1..x31 returns 0.
- **Write/read:**
  - Stimulus: write x5=0x12345678 and x6=0xFFFFFFFF, then request rs1=5, rs2=6 with `op_ready_i`=1.
  - Response: the next cycle shows `op_a_o`=0x12345678, `op_b_o`=0xFFFFFFFF, `op_valid_o`=1.
- **x0:** write x0=0xDEADBEEF, then request rs1=0, rs2=0 -> `op_a_o`=`op_b_o`=0.
- **Backpressure:**
  - Stimulus: `op_ready_i`=0 for 3 cycles after an accept (x5), with `rs_valid_i` held at 1 and a write x5=0xA5A5A5A5 during the stall.
  - Response: `rs_ready_o`=0, `op_a_o` stays 0x12345678 for all 3 cycles, and no request is lost.
  - When `op_ready_i`=1, the pending request is accepted the same cycle.
- **Same-edge write/read:**
  - Stimulus: `we_i`=1, `wa_i`=7, `wd_i`=0x55, simultaneous with an accept of rs1=7, rs2=7, where x7 was 0x11.
  - Response with `RF_BYPASS_EN` defined: `op_a_o`=`op_b_o`=0x55.
  - Response with it undefined: both are 0x11, and a following read returns 0x55.
- **Back-to-back:** 8 consecutive requests with `op_ready_i`=1 -> 8 consecutive valid cycles in order, with no bubbles.

Source files
------------

// File: rtl/riscv_operand_fetch.sv
// Register file (32 x XLEN) plus single-entry operand latch feeding the ALU stage.
// Optional write-through bypass on same-edge write/read: define RF_BYPASS_EN.
module riscv_operand_fetch #(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            rs_valid_i,
  output logic            rs_ready_o,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic [XLEN-1:0] op_a_o,
  output logic [XLEN-1:0] op_b_o,
  output logic            op_valid_o,
  input  logic            op_ready_i,
  input  logic            we_i,
  input  logic [4:0]      wa_i,
  input  logic [XLEN-1:0] wd_i
);

  // state | meaning
  // EMPTY | no operands held, op_valid_o=0
  // FULL  | operands held for the ALU, op_valid_o=1
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  localparam logic [5:0] RegNumW = 6'(REG_NUM);

  state_e          state_q, state_d;
  logic [XLEN-1:0] regs_q [REG_NUM];
  logic [XLEN-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [XLEN-1:0] rd_a, rd_b;
  logic            accept, wr_en;

  assign op_valid_o = (state_q == FULL);
  assign rs_ready_o = (state_q == EMPTY) || op_ready_i;
  assign accept     = rs_valid_i && rs_ready_o;
  assign wr_en      = we_i && (wa_i != 5'd0) && ({1'b0, wa_i} < RegNumW);
  assign op_a_o     = op_a_q;
  assign op_b_o     = op_b_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Reads see the array before the current edge; x0 and out-of-range indices read zero.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (rs1_addr_i != 5'd0 && {1'b0, rs1_addr_i} < RegNumW) rd_a = regs_q[rs1_addr_i];
    if (rs2_addr_i != 5'd0 && {1'b0, rs2_addr_i} < RegNumW) rd_b = regs_q[rs2_addr_i];
`ifdef RF_BYPASS_EN
    if (wr_en && wa_i == rs1_addr_i) rd_a = wd_i;
    if (wr_en && wa_i == rs2_addr_i) rd_b = wd_i;
`endif
  end

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FULL;
          op_a_d  = rd_a;
          op_b_d  = rd_b;
        end
      end
      FULL: begin
        if (accept) begin
          op_a_d = rd_a;
          op_b_d = rd_b;
        end else if (op_ready_i) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= EMPTY;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
    end
  end

endmodule

// File: tb/tb_riscv_operand_fetch.sv
// Directed bench for riscv_operand_fetch: reference register model, valid model and operand scoreboard.
module tb_riscv_operand_fetch;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        rs_valid_i, rs_ready_o;
  logic [4:0]  rs1_addr_i, rs2_addr_i;
  logic [31:0] op_a_o, op_b_o;
  logic        op_valid_o, op_ready_i;
  logic        we_i;
  logic [4:0]  wa_i;
  logic [31:0] wd_i;

  riscv_operand_fetch #(.XLEN(32), .REG_NUM(32)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .rs_valid_i(rs_valid_i), .rs_ready_o(rs_ready_o),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .op_a_o(op_a_o), .op_b_o(op_b_o),
    .op_valid_o(op_valid_o), .op_ready_i(op_ready_i),
    .we_i(we_i), .wa_i(wa_i), .wd_i(wd_i)
  );

  always #5 clk_i = ~clk_i;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] mdl [32];
  logic        mv;
  logic [31:0] last_a, last_b;
  logic [63:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mrd(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : mdl[a];
  endfunction

  // One clock: check ready, predict accept, advance, then check the operand latch.
  task automatic step();
    logic        exp_rdy, acc;
    logic [31:0] ea, eb;
    logic [63:0] item;
    #1;
    exp_rdy = !mv || op_ready_i;
    check("rs_ready", {31'b0, rs_ready_o}, {31'b0, exp_rdy});
    acc = rs_valid_i && exp_rdy;
    if (acc) begin
      ea = mrd(rs1_addr_i);
      eb = mrd(rs2_addr_i);
`ifdef RF_BYPASS_EN
      if (we_i && wa_i != 5'd0 && wa_i == rs1_addr_i) ea = wd_i;
      if (we_i && wa_i != 5'd0 && wa_i == rs2_addr_i) eb = wd_i;
`endif
      sb_q.push_back({ea, eb});
    end
    if (we_i && wa_i != 5'd0) mdl[wa_i] = wd_i;
    if (acc) mv = 1'b1;
    else if (op_ready_i) mv = 1'b0;
    @(posedge clk_i);
    #1;
    check("op_valid", {31'b0, op_valid_o}, {31'b0, mv});
    if (acc) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        item   = sb_q.pop_front();
        last_a = item[63:32];
        last_b = item[31:0];
        check("op_a", op_a_o, last_a);
        check("op_b", op_b_o, last_b);
      end
    end else if (mv) begin
      check("op_a_hold", op_a_o, last_a);
      check("op_b_hold", op_b_o, last_b);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; wa_i = a; wd_i = d;
    step();
    we_i = 1'b0;
  endtask

  task automatic req(input logic [4:0] a1, input logic [4:0] a2);
    rs_valid_i = 1'b1; rs1_addr_i = a1; rs2_addr_i = a2;
    step();
    rs_valid_i = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    mv = 1'b0; last_a = 32'h0; last_b = 32'h0;
    sb_q.delete();
  endtask

  initial begin
    rstn_i = 1'b0; rs_valid_i = 1'b0; rs1_addr_i = '0; rs2_addr_i = '0;
    op_ready_i = 1'b1; we_i = 1'b0; wa_i = '0; wd_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #2;
    check("rst_valid", {31'b0, op_valid_o}, 32'd0);
    check("rst_a", op_a_o, 32'h0);
    check("rst_b", op_b_o, 32'h0);
    check("rst_ready", {31'b0, rs_ready_o}, 32'd1);
    rstn_i = 1'b1;

    // write/read
    wr(5'd5, 32'h12345678);
    wr(5'd6, 32'hFFFFFFFF);
    req(5'd5, 5'd6);
    check("wr_rd_a", op_a_o, 32'h12345678);
    check("wr_rd_b", op_b_o, 32'hFFFFFFFF);

    // x0
    wr(5'd0, 32'hDEADBEEF);
    req(5'd0, 5'd0);
    check("x0_a", op_a_o, 32'h0);

    // backpressure with a write to the held register during the stall
    req(5'd5, 5'd5);
    op_ready_i = 1'b0;
    rs_valid_i = 1'b1; rs1_addr_i = 5'd6; rs2_addr_i = 5'd5;
    we_i = 1'b1; wa_i = 5'd5; wd_i = 32'hA5A5A5A5;
    step();
    we_i = 1'b0;
    step();
    step();
    check("stall_a", op_a_o, 32'h12345678);
    op_ready_i = 1'b1;
    step();
    rs_valid_i = 1'b0;
    check("post_stall_b", op_b_o, 32'hA5A5A5A5);
    step();

    // same-edge write/read
    wr(5'd7, 32'h11);
    rs_valid_i = 1'b1; rs1_addr_i = 5'd7; rs2_addr_i = 5'd7;
    we_i = 1'b1; wa_i = 5'd7; wd_i = 32'h55;
    step();
    we_i = 1'b0; rs_valid_i = 1'b0;
`ifdef RF_BYPASS_EN
    check("same_edge_a", op_a_o, 32'h55);
`else
    check("same_edge_a", op_a_o, 32'h11);
`endif
    req(5'd7, 5'd7);
    check("after_same_edge", op_b_o, 32'h55);

    // back-to-back
    for (int i = 1; i <= 8; i++) wr(5'(i + 8), 32'hC0DE0000 + 32'(i));
    rs_valid_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      rs1_addr_i = 5'(i + 8); rs2_addr_i = 5'(17 - i);
      step();
    end
    rs_valid_i = 1'b0;
    step();

    // asynchronous reset with operands held
    req(5'd5, 5'd6);
    op_ready_i = 1'b0;
    #3;
    rstn_i = 1'b0;
    #1;
    check("arst_valid", {31'b0, op_valid_o}, 32'd0);
    check("arst_a", op_a_o, 32'h0);
    check("arst_b", op_b_o, 32'h0);
    check("arst_ready", {31'b0, rs_ready_o}, 32'd1);
    model_reset();
    we_i = 1'b1; wa_i = 5'd3; wd_i = 32'hBADBAD00;
    @(posedge clk_i);
    #2;
    we_i = 1'b0;
    rstn_i = 1'b1;
    op_ready_i = 1'b1;
    for (int i = 1; i < 32; i++) req(5'(i), 5'(32 - i));
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
